// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down binary counter with registered Gray code and wrap pulse
module gray_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] g,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == ALL_ONES);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == '0);
            end
        end
        // Gray is encoded from the next binary value so both registers update on the same edge
        g_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            g_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            g_q    <= g_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign g    = g_q;
    assign wrap = wrap_q;

endmodule
